// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit (ifu_fetch, ifu_out_reg).
package ifu_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  localparam int unsigned XLEN_DEFAULT     = 64;
  localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;
  localparam int unsigned INST_W           = 32;
  localparam int unsigned INST_BYTES       = INST_W / 8;

endpackage

// File: rtl/ifu_out_reg.sv
// One-entry {pc, inst} holding register between instruction memory and the core.
// Contents stay frozen while the entry is valid and not consumed; flush discards it.
module ifu_out_reg
  import ifu_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst
);

  logic              valid_q, valid_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [INST_W-1:0] inst_q, inst_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (in_valid && in_ready) begin
      valid_d = 1'b1;
      pc_d    = in_pc;
      inst_d  = in_inst;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      inst_q  <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  assign in_ready  = !valid_q;
  assign out_valid = valid_q;
  assign out_pc    = pc_q;
  assign out_inst  = inst_q;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: one outstanding word fetch, redirect/kill handling, {pc,inst} to core.
// Optional IFU_PERF_CNT_EN adds perf_fetch_cnt / perf_drop_cnt outputs.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_resp_data,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [XLEN-1:0]   if_pc,
  output logic [INST_W-1:0] if_inst,
  input  logic              redir_valid,
  input  logic [XLEN-1:0]   redir_target
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [63:0]       perf_fetch_cnt,
  output logic [63:0]       perf_drop_cnt
`endif
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic            kill_q, kill_d;

  logic            hold_load, hold_flush, hold_in_ready, hold_valid;
  logic            drop_evt;
  logic [XLEN-1:0] target_aligned;
  logic            unused_target_lsbs;

  assign target_aligned     = {redir_target[XLEN-1:2], 2'b00};
  assign unused_target_lsbs = ^redir_target[1:0];

  // req_addr is separate from pc so an unaccepted request never changes address under a redirect.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    kill_d     = kill_q;
    hold_load  = 1'b0;
    hold_flush = 1'b0;
    drop_evt   = 1'b0;
    unique case (state_q)
      S_REQ: begin
        if (redir_valid) begin
          pc_d   = target_aligned;
          kill_d = 1'b1;
        end
        if (imem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          if (redir_valid || kill_q) begin
            drop_evt   = 1'b1;
            pc_d       = redir_valid ? target_aligned : pc_q;
            req_addr_d = pc_d;
            kill_d     = 1'b0;
            state_d    = S_REQ;
          end else if (hold_in_ready) begin
            hold_load = 1'b1;
            state_d   = S_HOLD;
          end
        end else if (redir_valid) begin
          pc_d   = target_aligned;
          kill_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redir_valid) begin
          hold_flush = 1'b1;
          pc_d       = target_aligned;
          req_addr_d = target_aligned;
          kill_d     = 1'b0;
          state_d    = S_REQ;
        end else if (if_ready) begin
          pc_d       = pc_q + XLEN'(INST_BYTES);
          req_addr_d = pc_d;
          state_d    = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      kill_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      kill_q     <= kill_d;
    end
  end

  ifu_out_reg #(
    .XLEN (XLEN)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (hold_flush),
    .in_valid  (hold_load),
    .in_ready  (hold_in_ready),
    .in_pc     (pc_q),
    .in_inst   (imem_resp_data),
    .out_valid (hold_valid),
    .out_ready (if_ready && !redir_valid),
    .out_pc    (if_pc),
    .out_inst  (if_inst)
  );

  // Gating with rst_n keeps both handshakes quiet for the whole reset cycle.
  assign imem_req_valid = rst_n && (state_q == S_REQ);
  assign imem_req_addr  = req_addr_q;
  assign if_valid       = rst_n && hold_valid && !redir_valid;

`ifdef IFU_PERF_CNT_EN
  logic [63:0] fetch_cnt_q, fetch_cnt_d;
  logic [63:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q + 64'(hold_load);
    drop_cnt_d  = drop_cnt_q + 64'(drop_evt);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_drop_cnt  = drop_cnt_q;
`else
  logic unused_drop_evt;
  assign unused_drop_evt = drop_evt;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed self-checking bench for ifu_fetch: sequential fetch, stalls, redirects, reset, PC wrap.
module tb_ifu_fetch;
  import ifu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic        if_ready;
  logic [63:0] if_pc;
  logic [31:0] if_inst;
  logic        redir_valid;
  logic [63:0] redir_target;
`ifdef IFU_PERF_CNT_EN
  logic [63:0] perf_fetch_cnt;
  logic [63:0] perf_drop_cnt;
`endif

  int   checks;
  int   passes;
  int   cyc;
  logic mem_auto;

  ifu_fetch dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_pc           (if_pc),
    .if_inst         (if_inst),
    .redir_valid     (redir_valid),
    .redir_target    (redir_target)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_drop_cnt   (perf_drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return a[31:0] ^ 32'h0013_0093;
  endfunction

  // One clock; when mem_auto is set, a request accepted at this edge answers in the next cycle.
  task automatic tick();
    logic        fire;
    logic [63:0] a;
    #1;
    fire = imem_req_valid && imem_req_ready;
    a    = imem_req_addr;
    @(posedge clk);
    #1;
    cyc++;
    if (mem_auto) begin
      imem_resp_valid = fire;
      imem_resp_data  = fire ? inst_of(a) : 32'h0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; redir_valid = 1'b0; redir_target = '0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    if_ready = 1'b0; mem_auto = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic wait_deliver(output logic ok);
    ok = 1'b0;
    if_ready = 1'b0; mem_auto = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (if_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; redir_valid = 1'b0; redir_target = '0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    if_ready = 1'b0; mem_auto = 1'b0;
    tick(); tick();
    checks++; if (imem_req_valid !== 1'b0) $display("[TB] FAIL rst_req_valid: got %b expected 0", imem_req_valid); else passes++;
    checks++; if (imem_req_addr !== 64'h8000_0000) $display("[TB] FAIL rst_req_addr: got %h expected 80000000", imem_req_addr); else passes++;
    checks++; if (if_valid !== 1'b0) $display("[TB] FAIL rst_if_valid: got %b expected 0", if_valid); else passes++;
    checks++; if (if_pc !== 64'h0 || if_inst !== 32'h0) $display("[TB] FAIL rst_if_data: got %h/%h expected 0/0", if_pc, if_inst); else passes++;
    rst_n = 1'b1;
    #1;
    checks++; if (imem_req_valid !== 1'b1) $display("[TB] FAIL release_req_valid: got %b expected 1", imem_req_valid); else passes++;
    checks++; if (imem_req_addr !== 64'h8000_0000) $display("[TB] FAIL release_req_addr: got %h expected 80000000", imem_req_addr); else passes++;
  endtask

  task automatic test_sequential_fetch();
    int          got;
    int          last_cyc;
    logic [63:0] exp_pc;
    got = 0; last_cyc = 0; exp_pc = 64'h8000_0000;
    mem_auto = 1'b1; imem_req_ready = 1'b1; if_ready = 1'b1;
    for (int i = 0; i < 30 && got < 3; i++) begin
      tick();
      if (if_valid) begin
        checks++; if (if_pc !== exp_pc) $display("[TB] FAIL seq_pc%0d: got %h expected %h", got, if_pc, exp_pc); else passes++;
        checks++; if (if_inst !== inst_of(exp_pc)) $display("[TB] FAIL seq_inst%0d: got %h expected %h", got, if_inst, inst_of(exp_pc)); else passes++;
        if (got > 0) begin
          checks++; if (cyc - last_cyc != 3) $display("[TB] FAIL seq_spacing%0d: got %0d expected 3", got, cyc - last_cyc); else passes++;
        end
        last_cyc = cyc; got++; exp_pc = exp_pc + 64'd4;
      end
    end
    checks++; if (got != 3) $display("[TB] FAIL seq_count: got %0d expected 3", got); else passes++;
  endtask

  task automatic test_req_stall();
    do_reset();
    mem_auto = 1'b1; imem_req_ready = 1'b0; if_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0000)
        $display("[TB] FAIL stall_req%0d: got %b/%h expected 1/80000000", i, imem_req_valid, imem_req_addr); else passes++;
    end
    imem_req_ready = 1'b1;
    tick();
    checks++; if (imem_req_valid !== 1'b0) $display("[TB] FAIL single_outstanding: got %b expected 0", imem_req_valid); else passes++;
    tick();
  endtask

  task automatic test_hold_stall();
    checks++; if (if_valid !== 1'b1 || if_pc !== 64'h8000_0000 || if_inst !== inst_of(64'h8000_0000))
      $display("[TB] FAIL hold_first: got %b/%h/%h expected 1/80000000/%h", if_valid, if_pc, if_inst, inst_of(64'h8000_0000)); else passes++;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (if_valid !== 1'b1 || if_pc !== 64'h8000_0000 || if_inst !== inst_of(64'h8000_0000) || imem_req_valid !== 1'b0)
        $display("[TB] FAIL hold_stable%0d: got %b/%h/%h req %b expected 1/80000000/%h req 0", i, if_valid, if_pc, if_inst, imem_req_valid, inst_of(64'h8000_0000)); else passes++;
    end
    if_ready = 1'b1;
    tick();
    checks++; if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0004)
      $display("[TB] FAIL hold_release: got %b/%b/%h expected 0/1/80000004", if_valid, imem_req_valid, imem_req_addr); else passes++;
  endtask

  task automatic test_redirect_wait();
    logic ok;
    mem_auto = 1'b0; imem_resp_valid = 1'b0;
    tick();
    redir_valid = 1'b1; redir_target = 64'h8000_0101;
    tick();
    redir_valid = 1'b0;
    checks++; if (imem_req_valid !== 1'b0) $display("[TB] FAIL redir_wait_noreq: got %b expected 0", imem_req_valid); else passes++;
    imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF;
    tick();
    imem_resp_valid = 1'b0;
    #1;
    checks++; if (if_valid !== 1'b0) $display("[TB] FAIL redir_wait_dropped: got %b expected 0", if_valid); else passes++;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0100)
      $display("[TB] FAIL redir_wait_addr: got %b/%h expected 1/80000100", imem_req_valid, imem_req_addr); else passes++;
`ifdef IFU_PERF_CNT_EN
    checks++; if (perf_drop_cnt !== 64'd1) $display("[TB] FAIL perf_drop_wait: got %0d expected 1", perf_drop_cnt); else passes++;
    checks++; if (perf_fetch_cnt !== 64'd1) $display("[TB] FAIL perf_fetch_wait: got %0d expected 1", perf_fetch_cnt); else passes++;
`endif
    wait_deliver(ok);
    checks++; if (!ok || if_pc !== 64'h8000_0100 || if_inst !== inst_of(64'h8000_0100))
      $display("[TB] FAIL redir_wait_deliver: got %b/%h/%h expected 1/80000100/%h", ok, if_pc, if_inst, inst_of(64'h8000_0100)); else passes++;
  endtask

  task automatic test_redirect_hold();
    logic ok;
    if_ready = 1'b1; redir_valid = 1'b1; redir_target = 64'h8000_0200;
    #1;
    checks++; if (if_valid !== 1'b0) $display("[TB] FAIL redir_hold_mask: got %b expected 0", if_valid); else passes++;
    tick();
    redir_valid = 1'b0;
    #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0200)
      $display("[TB] FAIL redir_hold_addr: got %b/%h expected 1/80000200", imem_req_valid, imem_req_addr); else passes++;
    wait_deliver(ok);
    checks++; if (!ok || if_pc !== 64'h8000_0200)
      $display("[TB] FAIL redir_hold_deliver: got %b/%h expected 1/80000200", ok, if_pc); else passes++;
  endtask

  task automatic test_reset_mid_wait();
    logic ok;
    mem_auto = 1'b0; imem_resp_valid = 1'b0; if_ready = 1'b1; imem_req_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    checks++; if (imem_req_valid !== 1'b0 || if_valid !== 1'b0 || imem_req_addr !== 64'h8000_0000)
      $display("[TB] FAIL midrst_outputs: got %b/%b/%h expected 0/0/80000000", imem_req_valid, if_valid, imem_req_addr); else passes++;
    rst_n = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h0BAD_F00D;
    tick();
    imem_resp_valid = 1'b0;
    #1;
    checks++; if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0000)
      $display("[TB] FAIL midrst_stale: got %b/%b/%h expected 0/1/80000000", if_valid, imem_req_valid, imem_req_addr); else passes++;
    imem_req_ready = 1'b1;
    wait_deliver(ok);
    checks++; if (!ok || if_pc !== 64'h8000_0000 || if_inst !== inst_of(64'h8000_0000))
      $display("[TB] FAIL midrst_restart: got %b/%h/%h expected 1/80000000/%h", ok, if_pc, if_inst, inst_of(64'h8000_0000)); else passes++;
`ifdef IFU_PERF_CNT_EN
    checks++; if (perf_drop_cnt !== 64'd0 || perf_fetch_cnt !== 64'd1)
      $display("[TB] FAIL midrst_perf: got %0d/%0d expected 0/1", perf_drop_cnt, perf_fetch_cnt); else passes++;
`endif
  endtask

  task automatic test_redirect_req_wrap();
    logic ok;
    imem_req_ready = 1'b0; if_ready = 1'b1;
    tick();
    redir_valid = 1'b1; redir_target = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    redir_valid = 1'b0;
    #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0004)
      $display("[TB] FAIL redir_req_stable: got %b/%h expected 1/80000004", imem_req_valid, imem_req_addr); else passes++;
    imem_req_ready = 1'b1; mem_auto = 1'b1;
    tick();
    tick();
    checks++; if (if_valid !== 1'b0 || imem_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC)
      $display("[TB] FAIL redir_req_kill: got %b/%h expected 0/fffffffffffffffc", if_valid, imem_req_addr); else passes++;
`ifdef IFU_PERF_CNT_EN
    checks++; if (perf_drop_cnt !== 64'd1) $display("[TB] FAIL perf_drop_req: got %0d expected 1", perf_drop_cnt); else passes++;
`endif
    wait_deliver(ok);
    checks++; if (!ok || if_pc !== 64'hFFFF_FFFF_FFFF_FFFC || if_inst !== inst_of(64'hFFFF_FFFF_FFFF_FFFC))
      $display("[TB] FAIL wrap_deliver: got %b/%h/%h expected 1/fffffffffffffffc/%h", ok, if_pc, if_inst, inst_of(64'hFFFF_FFFF_FFFF_FFFC)); else passes++;
    if_ready = 1'b1;
    tick();
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h0)
      $display("[TB] FAIL wrap_next_addr: got %b/%h expected 1/0", imem_req_valid, imem_req_addr); else passes++;
  endtask

  initial begin
    checks = 0; passes = 0; cyc = 0; mem_auto = 1'b0;
    rst_n = 1'b0; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    if_ready = 1'b0; redir_valid = 1'b0; redir_target = '0;
    test_reset();
    test_sequential_fetch();
    test_req_stall();
    test_hold_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_reset_mid_wait();
    test_redirect_req_wrap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
